gci_std_display_vram_arbiter: RTL and testbench

//  Shares the single VRAM port between two masters: M0 (display read engine) and M1 (user write/read IF).

---
 rtl/gci_std_display_vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_gci_std_display_vram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gci_std_display_vram_arbiter.sv
// Two-master VRAM port arbiter: grants one owner via REQ/ACK/FINISH, muxes its commands,
// and routes read returns back to it until every outstanding read has come home.
module gci_std_display_vram_arbiter #(
  parameter int P_MEM_ADDR_N  = 19,
  parameter int P_OUTSTD_N    = 3,
  parameter int P_M0_PRIORITY = 1
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iM0_ARBIT_REQ,
  output logic                    oM0_ARBIT_ACK,
  input  logic                    iM0_ARBIT_FINISH,
  input  logic                    iM0_ENA,
  output logic                    oM0_BUSY,
  input  logic                    iM0_RW,
  input  logic [P_MEM_ADDR_N-1:0] iM0_ADDR,
  input  logic [31:0]             iM0_DATA,
  output logic                    oM0_VALID,
  output logic [31:0]             oM0_DATA,
  input  logic                    iM0_BUSY,
  input  logic                    iM1_ARBIT_REQ,
  output logic                    oM1_ARBIT_ACK,
  input  logic                    iM1_ARBIT_FINISH,
  input  logic                    iM1_ENA,
  output logic                    oM1_BUSY,
  input  logic                    iM1_RW,
  input  logic [P_MEM_ADDR_N-1:0] iM1_ADDR,
  input  logic [31:0]             iM1_DATA,
  output logic                    oM1_VALID,
  output logic [31:0]             oM1_DATA,
  input  logic                    iM1_BUSY,
  output logic                    oVRAM_ENA,
  input  logic                    iVRAM_BUSY,
  output logic                    oVRAM_RW,
  output logic [P_MEM_ADDR_N-1:0] oVRAM_ADDR,
  output logic [31:0]             oVRAM_DATA,
  input  logic                    iVRAM_VALID,
  output logic                    oVRAM_BUSY,
  input  logic [31:0]             iVRAM_DATA
);

  typedef enum logic [1:0] {IDLE, GRANT, OWN, DRAIN} state_t;

  localparam logic [P_OUTSTD_N-1:0] CNT_MAX = '1;

  state_t                  state, state_nxt;
  logic                    owner, owner_nxt;
  logic                    rr_last, rr_nxt;
  logic [P_OUTSTD_N-1:0]   cnt, cnt_nxt;

  logic [1:0]                    req, fin, ena, rw, mbusy_in;
  logic [1:0][P_MEM_ADDR_N-1:0]  addr;
  logic [1:0][31:0]              wdata, rdata;
  logic [1:0]                    ack, mbusy, mvalid;
  logic                          rd_full, accept_rd, retire;

  assign req      = {iM1_ARBIT_REQ, iM0_ARBIT_REQ};
  assign fin      = {iM1_ARBIT_FINISH, iM0_ARBIT_FINISH};
  assign ena      = {iM1_ENA, iM0_ENA};
  assign rw       = {iM1_RW, iM0_RW};
  assign mbusy_in = {iM1_BUSY, iM0_BUSY};
  assign addr     = {iM1_ADDR, iM0_ADDR};
  assign wdata    = {iM1_DATA, iM0_DATA};
  assign rd_full  = (cnt == CNT_MAX);

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_nxt     = rr_last;
    cnt_nxt    = cnt;
    ack        = '0;
    mbusy      = '1;
    mvalid     = '0;
    rdata      = '0;
    oVRAM_ENA  = 1'b0;
    oVRAM_RW   = 1'b0;
    oVRAM_ADDR = '0;
    oVRAM_DATA = '0;
    oVRAM_BUSY = 1'b0;
    accept_rd  = 1'b0;
    retire     = 1'b0;
    if (!iRESET_SYNC) begin
      case (state)
        IDLE: if (|req) begin
          state_nxt = GRANT;
          if (&req) owner_nxt = (P_M0_PRIORITY != 0) ? 1'b0 : ~rr_last;
          else      owner_nxt = req[1];
        end
        GRANT: begin
          ack[owner] = 1'b1;
          rr_nxt     = owner;
          state_nxt  = OWN;
        end
        OWN: begin
          // A read at the counter limit is held off the VRAM port, not just backpressured.
          oVRAM_ENA    = ena[owner] && !(!rw[owner] && rd_full);
          oVRAM_RW     = rw[owner];
          oVRAM_ADDR   = addr[owner];
          oVRAM_DATA   = wdata[owner];
          mbusy[owner] = iVRAM_BUSY | (!rw[owner] && rd_full);
          accept_rd    = oVRAM_ENA && !iVRAM_BUSY && !rw[owner];
          if (fin[owner]) state_nxt = DRAIN;
        end
        DRAIN: if (cnt == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      // Returns with nothing outstanding are stray and silently consumed.
      if ((state == OWN || state == DRAIN) && cnt != '0) begin
        mvalid[owner] = iVRAM_VALID;
        rdata[owner]  = iVRAM_DATA;
        oVRAM_BUSY    = mbusy_in[owner];
        retire        = iVRAM_VALID && !mbusy_in[owner];
      end
      if (accept_rd && !retire)      cnt_nxt = cnt + 1'b1;
      else if (!accept_rd && retire) cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      cnt     <= '0;
    end else if (iRESET_SYNC) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rr_last <= 1'b1;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_last <= rr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign oM0_ARBIT_ACK = ack[0];
  assign oM1_ARBIT_ACK = ack[1];
  assign oM0_BUSY      = mbusy[0];
  assign oM1_BUSY      = mbusy[1];
  assign oM0_VALID     = mvalid[0];
  assign oM1_VALID     = mvalid[1];
  assign oM0_DATA      = rdata[0];
  assign oM1_DATA      = rdata[1];

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// Directed bench for the VRAM arbiter: fixed-priority instance for ownership/drain/backpressure,
// round-robin instance for tie alternation; read returns checked against an expected-data queue.
module tb_gci_std_display_vram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rsync;
  logic req0, req1, fin0, fin1, ena0, ena1, rw0, rw1, mb0, mb1;
  logic [18:0] addr0, addr1;
  logic [31:0] wd0, wd1;
  logic vram_busy_i, vram_valid_i;
  logic [31:0] vram_rdata;
  logic ack0, ack1, busy0, busy1, valid0, valid1;
  logic [31:0] rdata0, rdata1;
  logic vram_ena, vram_rw, vram_busy_o;
  logic [18:0] vram_addr;
  logic [31:0] vram_wdata;

  logic r_req0, r_req1, r_fin0, r_fin1;
  logic r_ack0, r_ack1, r_busy0, r_busy1, r_valid0, r_valid1, r_vena, r_vrw, r_vbusy;
  logic [31:0] r_rd0, r_rd1, r_vdata;
  logic [18:0] r_vaddr;

  int n_chk = 0, n_pass = 0, n_fail = 0, n_acc = 0;
  logic [31:0] q0[$], q1[$];
  logic [31:0] e0, e1;

  gci_std_display_vram_arbiter #(.P_MEM_ADDR_N(19), .P_OUTSTD_N(3), .P_M0_PRIORITY(1)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rsync),
    .iM0_ARBIT_REQ(req0), .oM0_ARBIT_ACK(ack0), .iM0_ARBIT_FINISH(fin0),
    .iM0_ENA(ena0), .oM0_BUSY(busy0), .iM0_RW(rw0), .iM0_ADDR(addr0), .iM0_DATA(wd0),
    .oM0_VALID(valid0), .oM0_DATA(rdata0), .iM0_BUSY(mb0),
    .iM1_ARBIT_REQ(req1), .oM1_ARBIT_ACK(ack1), .iM1_ARBIT_FINISH(fin1),
    .iM1_ENA(ena1), .oM1_BUSY(busy1), .iM1_RW(rw1), .iM1_ADDR(addr1), .iM1_DATA(wd1),
    .oM1_VALID(valid1), .oM1_DATA(rdata1), .iM1_BUSY(mb1),
    .oVRAM_ENA(vram_ena), .iVRAM_BUSY(vram_busy_i), .oVRAM_RW(vram_rw),
    .oVRAM_ADDR(vram_addr), .oVRAM_DATA(vram_wdata), .iVRAM_VALID(vram_valid_i),
    .oVRAM_BUSY(vram_busy_o), .iVRAM_DATA(vram_rdata)
  );

  gci_std_display_vram_arbiter #(.P_MEM_ADDR_N(19), .P_OUTSTD_N(3), .P_M0_PRIORITY(0)) dut_rr (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rsync),
    .iM0_ARBIT_REQ(r_req0), .oM0_ARBIT_ACK(r_ack0), .iM0_ARBIT_FINISH(r_fin0),
    .iM0_ENA(1'b0), .oM0_BUSY(r_busy0), .iM0_RW(1'b0), .iM0_ADDR(19'd0), .iM0_DATA(32'd0),
    .oM0_VALID(r_valid0), .oM0_DATA(r_rd0), .iM0_BUSY(1'b0),
    .iM1_ARBIT_REQ(r_req1), .oM1_ARBIT_ACK(r_ack1), .iM1_ARBIT_FINISH(r_fin1),
    .iM1_ENA(1'b0), .oM1_BUSY(r_busy1), .iM1_RW(1'b0), .iM1_ADDR(19'd0), .iM1_DATA(32'd0),
    .oM1_VALID(r_valid1), .oM1_DATA(r_rd1), .iM1_BUSY(1'b0),
    .oVRAM_ENA(r_vena), .iVRAM_BUSY(1'b0), .oVRAM_RW(r_vrw),
    .oVRAM_ADDR(r_vaddr), .oVRAM_DATA(r_vdata), .iVRAM_VALID(1'b0),
    .oVRAM_BUSY(r_vbusy), .iVRAM_DATA(32'd0)
  );

  function automatic logic [31:0] dat(input logic [18:0] a);
    return 32'hDEAD_0000 ^ {13'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Read-return scoreboard and VRAM command acceptance counter.
  always @(negedge clk) begin
    if (valid0 === 1'b1 && mb0 === 1'b0) begin
      if (q0.size() == 0) chk("m0_unexpected_valid", {31'd0, valid0}, 32'd0);
      else begin e0 = q0.pop_front(); chk("m0_rdata", rdata0, e0); end
    end
    if (valid1 === 1'b1 && mb1 === 1'b0) begin
      if (q1.size() == 0) chk("m1_unexpected_valid", {31'd0, valid1}, 32'd0);
      else begin e1 = q1.pop_front(); chk("m1_rdata", rdata1, e1); end
    end
    if (vram_ena === 1'b1 && vram_busy_i === 1'b0) n_acc++;
  end

  initial begin
    int acc0;
    int gq[$];
    logic got, who;
    int expw;

    rst_n = 1'b0; rsync = 1'b0;
    req0 = 1'b1; req1 = 1'b1; fin0 = 1'b0; fin1 = 1'b0;
    ena0 = 1'b0; ena1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0; mb0 = 1'b0; mb1 = 1'b0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    vram_busy_i = 1'b0; vram_valid_i = 1'b0; vram_rdata = '0;
    r_req0 = 1'b0; r_req1 = 1'b0; r_fin0 = 1'b0; r_fin1 = 1'b0;

    // T1: reset values, then M0 wins the tie
    mid();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_vram_ena", vram_ena, 0);
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_valid0", valid0, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_busy", vram_busy_o, 0);
    #2 rst_n = 1'b1;
    tick();
    mid();
    chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    chk("t1_grant_ena", vram_ena, 0);
    chk("t1_grant_busy0", busy0, 1);
    tick();

    // T2: M0 issues 3 reads, FINISH with the third, then drains
    req0 = 1'b0; ena0 = 1'b1; rw0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr0 = 19'h0_0A00 + 19'(i);
      if (i == 2) fin0 = 1'b1;
      mid();
      chk("t2_ack0_low", ack0, 0);
      chk("t2_vram_ena", vram_ena, 1);
      chk("t2_vram_addr", vram_addr, addr0);
      chk("t2_busy0", busy0, 0);
      chk("t2_busy1_nonowner", busy1, 1);
      q0.push_back(dat(addr0));
      tick();
    end
    fin0 = 1'b0; addr0 = 19'h0_0AFF;
    mid();
    chk("t2_drain_ena", vram_ena, 0);
    chk("t2_drain_busy0", busy0, 1);
    tick();
    ena0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vram_valid_i = 1'b1; vram_rdata = dat(19'h0_0A00 + 19'(i));
      mid();
      chk("t2_ret_valid0", valid0, 1);
      chk("t2_ret_valid1", valid1, 0);
      tick();
    end
    vram_valid_i = 1'b0;
    mid();
    chk("t2_drain_last_ack1", ack1, 0);
    tick();
    mid();
    chk("t2_idle_ack1", ack1, 0);
    tick();
    mid();
    chk("t2_m1_ack", ack1, 1);
    chk("t2_m1_ack0", ack0, 0);
    tick();

    // T5: stalled write from M1; non-owner M0 ENA must not reach VRAM
    req1 = 1'b0; ena1 = 1'b1; rw1 = 1'b1; addr1 = 19'h1234; wd1 = 32'hCAFE_F00D;
    vram_busy_i = 1'b1; acc0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      ena0 = i[0]; addr0 = 19'h7_0000 + 19'(i);
      mid();
      chk("t5_ena", vram_ena, 1);
      chk("t5_addr", vram_addr, 19'h1234);
      chk("t5_data", vram_wdata, 32'hCAFE_F00D);
      chk("t5_rw", vram_rw, 1);
      chk("t5_busy1", busy1, 1);
      chk("t5_busy0", busy0, 1);
      tick();
    end
    vram_busy_i = 1'b0; ena0 = 1'b1;
    mid();
    chk("t5_busy1_free", busy1, 0);
    chk("t5_addr_free", vram_addr, 19'h1234);
    tick();
    ena1 = 1'b0;
    mid();
    chk("t5_nonowner_ena", vram_ena, 0);
    tick();
    ena0 = 1'b0;
    chk("t5_accept_once", n_acc - acc0, 1);

    // T4: 8 reads with no return; 8th blocked until one retires
    ena1 = 1'b1; rw1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      addr1 = 19'h100 + 19'(i);
      mid();
      chk("t4_rd_busy1", busy1, 0);
      q1.push_back(dat(addr1));
      tick();
    end
    addr1 = 19'h107;
    mid();
    chk("t4_full_busy1", busy1, 1);
    chk("t4_full_noena", vram_ena, 0);
    tick();
    vram_valid_i = 1'b1; vram_rdata = dat(19'h100);
    mid();
    chk("t4_retire_busy1", busy1, 1);
    tick();
    vram_valid_i = 1'b0;
    mid();
    chk("t4_8th_busy1", busy1, 0);
    q1.push_back(dat(19'h107));
    tick();
    ena1 = 1'b0; fin1 = 1'b1;
    tick();
    fin1 = 1'b0;
    for (int i = 1; i < 6; i++) begin
      vram_valid_i = 1'b1; vram_rdata = dat(19'h100 + 19'(i));
      tick();
    end

    // T6: sync clear in DRAIN with 2 outstanding; late returns are dropped
    rsync = 1'b1; vram_valid_i = 1'b1; vram_rdata = dat(19'h106);
    mid();
    chk("t6_sync_valid1", valid1, 0);
    chk("t6_sync_busy1", busy1, 1);
    tick();
    rsync = 1'b0; q1.delete();
    vram_rdata = dat(19'h107); req0 = 1'b1;
    mid();
    chk("t6_late_valid1", valid1, 0);
    chk("t6_late_valid0", valid0, 0);
    tick();
    vram_valid_i = 1'b0;
    mid();
    chk("t6_regrant_ack0", ack0, 1);
    tick();
    req0 = 1'b0; vram_valid_i = 1'b1; vram_rdata = 32'h5555_AAAA;
    mid();
    chk("t6_cnt_zero_drop", valid0, 0);
    chk("t6_cnt_zero_vbusy", vram_busy_o, 0);
    tick();
    vram_valid_i = 1'b0; fin0 = 1'b1;
    tick();
    fin0 = 1'b0;
    tick();
    tick();
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);

    // T3: round-robin on continuous ties
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    r_req0 = 1'b1; r_req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; who = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (!got) begin
          mid();
          if (r_ack0 === 1'b1 || r_ack1 === 1'b1) begin
            got = 1'b1; who = r_ack1;
            chk("t3_single_ack", r_ack0 & r_ack1, 0);
          end else tick();
        end
      end
      chk("t3_ack_seen", got, 1);
      expw = gq.pop_front();
      chk("t3_winner", who, expw);
      tick();
      if (who) r_fin1 = 1'b1; else r_fin0 = 1'b1;
      tick();
      r_fin0 = 1'b0; r_fin1 = 1'b0;
    end
    r_req0 = 1'b0; r_req1 = 1'b0;
    mid();
    chk("t3_rr_vena", r_vena, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
